// File: rtl/motoro3_pwm_multi_if.sv
// Control/gate-drive bundle between the commutation logic and the PWM block.
// Master drives the per-period settings; slave returns gate drives and strobes.
interface motoro3_pwm_multi_if #(
    parameter int CH     = 3,
    parameter int CNT_W  = 12,
    parameter int LEN_W  = 16,
    parameter int DEAD_W = 6
);
    logic [CNT_W-1:0]    periodLen;
    logic                syncIn;
    logic [CNT_W-1:0]    minMask;
    logic [DEAD_W-1:0]   deadLen;
    logic [CH-1:0]       chEn;
    logic [CH*LEN_W-1:0] dutyLen;
    logic [CH-1:0]       pwmH;
    logic [CH-1:0]       pwmL;
    logic                perStart;
    logic [CH-1:0]       pwmSkip;

    modport master (
        output periodLen, syncIn, minMask, deadLen, chEn, dutyLen,
        input  pwmH, pwmL, perStart, pwmSkip
    );

    modport slave (
        input  periodLen, syncIn, minMask, deadLen, chEn, dutyLen,
        output pwmH, pwmL, perStart, pwmSkip
    );
endinterface

// File: rtl/motoro3_pwm_multi.sv
// Multi-channel complementary PWM: shared timebase, per-leg duty latch with
// min-pulse carry, and a dead-time gate FSM per high/low pair.
module motoro3_pwm_multi #(
    parameter int CH     = 3,
    parameter int CNT_W  = 12,
    parameter int LEN_W  = 16,
    parameter int DEAD_W = 6
) (
    input logic clk,
    input logic rst,
    motoro3_pwm_multi_if.slave bus
);
    localparam int SUM_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_LOW,
        S_DEAD1,
        S_HIGH,
        S_DEAD2
    } gate_t;

    logic [CNT_W-1:0] per_cnt;
    logic             run;
    logic             per_start;
    logic             dead_zero;
    logic [DEAD_W-1:0] dead_load;
    logic [CH-1:0]    h_vec;
    logic [CH-1:0]    l_vec;
    logic [CH-1:0]    skip_vec;

    assign run       = bus.periodLen != '0;
    assign per_start = run & ~rst & (bus.syncIn | (per_cnt <= CNT_W'(1)));
    assign dead_zero = bus.deadLen == '0;
    // Loaded one short so each dead state lasts exactly deadLen cycles
    assign dead_load = bus.deadLen - DEAD_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (!run) begin
            per_cnt <= '0;
        end else if (per_start) begin
            per_cnt <= bus.periodLen;
        end else if (per_cnt != '0) begin
            per_cnt <= per_cnt - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [LEN_W-1:0]  duty;
        logic [SUM_W-1:0]  rem;
        logic [SUM_W-1:0]  sum;
        logic [CNT_W-1:0]  pulse;
        logic [CNT_W-1:0]  on_cnt;
        logic              below;
        logic              en;
        logic              raw;
        logic              skip_q;
        logic              h_q;
        logic              l_q;
        logic [DEAD_W-1:0] dc;
        logic [DEAD_W-1:0] dc_nxt;
        gate_t             state;
        gate_t             nxt;

        assign duty  = bus.dutyLen[i*LEN_W +: LEN_W];
        assign en    = bus.chEn[i];
        assign sum   = rem + SUM_W'(duty);
        assign below = sum < SUM_W'(bus.minMask);
        assign pulse = (sum > SUM_W'(bus.periodLen)) ? bus.periodLen
                                                     : sum[CNT_W-1:0];
        assign raw   = on_cnt != '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rem    <= '0;
                on_cnt <= '0;
                skip_q <= 1'b0;
            end else if (!run || !en) begin
                rem    <= '0;
                on_cnt <= '0;
                skip_q <= 1'b0;
            end else begin
                skip_q <= 1'b0;
                if (per_start) begin
                    if (below) begin
                        rem    <= sum;
                        on_cnt <= '0;
                        skip_q <= 1'b1;
                    end else begin
                        rem    <= '0;
                        on_cnt <= pulse;
                    end
                end else if (on_cnt != '0) begin
                    on_cnt <= on_cnt - CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= S_OFF;
                dc    <= '0;
                h_q   <= 1'b0;
                l_q   <= 1'b0;
            end else begin
                state <= nxt;
                dc    <= dc_nxt;
                h_q   <= nxt == S_HIGH;
                l_q   <= nxt == S_LOW;
            end
        end

        always_comb begin
            nxt    = state;
            dc_nxt = (dc != '0) ? dc - DEAD_W'(1) : dc;
            if (!run || !en) begin
                nxt = S_OFF;
            end else begin
                unique case (state)
                    S_OFF: nxt = S_LOW;
                    S_LOW: begin
                        if (raw) begin
                            nxt    = dead_zero ? S_HIGH : S_DEAD1;
                            dc_nxt = dead_load;
                        end
                    end
                    S_DEAD1: begin
                        if (dc == '0) nxt = raw ? S_HIGH : S_DEAD2;
                    end
                    S_HIGH: begin
                        if (!raw) begin
                            nxt    = dead_zero ? S_LOW : S_DEAD2;
                            dc_nxt = dead_load;
                        end
                    end
                    S_DEAD2: begin
                        if (dc == '0) nxt = S_LOW;
                    end
                    default: nxt = S_OFF;
                endcase
            end
        end

        assign h_vec[i]    = h_q;
        assign l_vec[i]    = l_q;
        assign skip_vec[i] = skip_q;
    end

    assign bus.pwmH     = h_vec;
    assign bus.pwmL     = l_vec;
    assign bus.pwmSkip  = skip_vec;
    assign bus.perStart = per_start;
endmodule

// File: tb/tb_motoro3_pwm_multi.sv
// Directed bench for motoro3_pwm_multi (CH=3 main build, CH=6/LEN_W=8 side build).
// Window counts of H/L/perStart/skip are compared against hand-derived values.
module tb_motoro3_pwm_multi;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    motoro3_pwm_multi_if #(.CH(3), .CNT_W(12), .LEN_W(16), .DEAD_W(6)) b3 ();
    motoro3_pwm_multi_if #(.CH(6), .CNT_W(12), .LEN_W(8), .DEAD_W(6)) b6 ();

    motoro3_pwm_multi #(.CH(3), .CNT_W(12), .LEN_W(16), .DEAD_W(6)) dut3 (
        .clk(clk),
        .rst(rst),
        .bus(b3)
    );

    motoro3_pwm_multi #(.CH(6), .CNT_W(12), .LEN_W(8), .DEAD_W(6)) dut6 (
        .clk(clk),
        .rst(rst),
        .bus(b6)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ov3 = 0;
    int ov6 = 0;
    int hc[3];
    int lc[3];
    int bl0;
    int psc;
    int skc0;
    int h6[6];
    int k;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (|(b3.pwmH & b3.pwmL)) ov3++;
        if (|(b6.pwmH & b6.pwmL)) ov6++;
    end

    task automatic run(input int n);
        for (int i = 0; i < 3; i++) begin
            hc[i] = 0;
            lc[i] = 0;
        end
        bl0  = 0;
        psc  = 0;
        skc0 = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                hc[i] += int'(b3.pwmH[i]);
                lc[i] += int'(b3.pwmL[i]);
            end
            bl0  += int'(!b3.pwmH[0] && !b3.pwmL[0]);
            psc  += int'(b3.perStart);
            skc0 += int'(b3.pwmSkip[0]);
        end
    endtask

    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b3.perStart && n < 300);
        if (!b3.perStart) chk("perstart_timeout", 0, 1);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        b3.periodLen = 12'd100;
        b3.syncIn    = 1'b0;
        b3.minMask   = 12'd0;
        b3.deadLen   = 6'd0;
        b3.chEn      = 3'b111;
        b3.dutyLen   = {3{16'd30}};
        b6.periodLen = 12'd100;
        b6.syncIn    = 1'b0;
        b6.minMask   = 12'd0;
        b6.deadLen   = 6'd0;
        b6.chEn      = 6'b111111;
        b6.dutyLen   = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};

        @(negedge clk);
        chk("rst_pwmH", int'(b3.pwmH), 0);
        chk("rst_pwmL", int'(b3.pwmL), 0);
        chk("rst_perStart", int'(b3.perStart), 0);
        chk("rst_pwmSkip", int'(b3.pwmSkip), 0);
        edge1();
        rst = 1'b0;
        @(negedge clk);
        chk("first_perStart", int'(b3.perStart), 1);

        // duty 30, no dead time
        run(150);
        run(200);
        chk("d30_ps", psc, 2);
        chk("d30_h0", hc[0], 60);
        chk("d30_l0", lc[0], 140);
        chk("d30_h2", hc[2], 60);
        chk("d30_gap", bl0, 0);

        // dead time 4
        edge1();
        b3.deadLen = 6'd4;
        run(150);
        run(200);
        chk("dead4_h0", hc[0], 52);
        chk("dead4_l0", lc[0], 132);
        chk("dead4_gap", bl0, 16);
        wait_ps();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!b3.pwmH[0] && k < 20);
        chk("dead4_rise", k, 6);

        // min-pulse accumulation
        edge1();
        b3.deadLen = 6'd0;
        b3.minMask = 12'd32;
        b3.dutyLen = {3{16'd12}};
        wait_ps();
        run(100);
        chk("min_p1_skip", skc0, 1);
        chk("min_p1_h", hc[0], 0);
        run(100);
        chk("min_p2_skip", skc0, 1);
        chk("min_p2_h", hc[0], 0);
        run(100);
        chk("min_p3_skip", skc0, 0);
        chk("min_p3_h", hc[0], 36);
        chk("min_p3_l", lc[0], 64);

        // duty above period, then sync restart
        edge1();
        b3.minMask = 12'd0;
        b3.deadLen = 6'd4;
        b3.dutyLen = {3{16'd500}};
        run(250);
        run(200);
        chk("big_h0", hc[0], 200);
        chk("big_l0", lc[0], 0);
        wait_ps();
        run(60);
        edge1();
        b3.syncIn  = 1'b1;
        b3.deadLen = 6'd0;
        b3.dutyLen = {3{16'd30}};
        @(negedge clk);
        chk("sync_ps", int'(b3.perStart), 1);
        edge1();
        b3.syncIn = 1'b0;
        run(99);
        chk("sync_noearly_ps", psc, 0);
        chk("sync_h0", hc[0], 31);
        @(negedge clk);
        chk("sync_next_ps", int'(b3.perStart), 1);

        // channel disable during HIGH
        run(3);
        chk("chen_pre_h1", int'(b3.pwmH[1]), 1);
        edge1();
        b3.chEn = 3'b101;
        edge1();
        @(negedge clk);
        chk("chen_off_h1", int'(b3.pwmH[1]), 0);
        chk("chen_off_l1", int'(b3.pwmL[1]), 0);
        chk("chen_off_h0", int'(b3.pwmH[0]), 1);
        edge1();
        b3.chEn = 3'b111;
        edge1();
        @(negedge clk);
        chk("chen_re_l1", int'(b3.pwmL[1]), 1);
        chk("chen_re_h1", int'(b3.pwmH[1]), 0);

        // idle period
        edge1();
        b3.periodLen = 12'd0;
        edge1();
        run(50);
        chk("idle_ps", psc, 0);
        chk("idle_h0", hc[0], 0);
        chk("idle_l0", lc[0], 0);

        // reset mid-pulse
        edge1();
        b3.periodLen = 12'd100;
        wait_ps();
        run(5);
        chk("rst_pre_h0", int'(b3.pwmH[0]), 1);
        edge1();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_h", int'(b3.pwmH), 0);
        chk("rst_mid_l", int'(b3.pwmL), 0);
        chk("rst_mid_ps", int'(b3.perStart), 0);
        edge1();
        rst = 1'b0;

        // six-channel build, independent duties
        repeat (150) @(negedge clk);
        for (int i = 0; i < 6; i++) h6[i] = 0;
        repeat (200) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) h6[i] += int'(b6.pwmH[i]);
        end
        for (int i = 0; i < 6; i++) chk($sformatf("ch6_h%0d", i), h6[i], 20 * (i + 1));

        // random stress on the six-channel build
        for (int c = 0; c < 400; c++) begin
            edge1();
            b6.dutyLen = 48'({$urandom(), $urandom()});
            b6.deadLen = 6'($urandom_range(0, 8));
            b6.chEn    = 6'($urandom_range(0, 63));
            b6.syncIn  = ($urandom_range(0, 19) == 0);
            b6.minMask = 12'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) b6.periodLen = 12'($urandom_range(0, 60));
        end
        edge1();
        chk("no_overlap_ch3", ov3, 0);
        chk("no_overlap_ch6", ov6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
